// File: rtl/bus_memory_pkg.sv
// bus_memory_pkg: shared widths and FSM state encoding for bus_memory.
package bus_memory_pkg;
  localparam int WORD_W = 32;
  localparam int SEL_W = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/bus_memory_array.sv
// bus_memory_array: synchronous single-port RAM, read-before-write, optional byte lanes (BUS_MEMORY_BYTE_SEL_EN).
module bus_memory_array
  import bus_memory_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  input  logic [SEL_W-1:0]     sel,
  output logic [WORD_W-1:0]    rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_BITS];
  initial
    for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] = '0;
`ifdef BUS_MEMORY_BYTE_SEL_EN
  always @(posedge clk)
    for (int i = 0; i < SEL_W; i++)
      if (we && sel[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
`else
  logic unused_sel;
  assign unused_sel = ^sel;
  always @(posedge clk)
    if (we) mem[addr] <= wdata;
`endif
  always_ff @(posedge clk)
    if (reset) rdata <= '0;
    else if (en) rdata <= mem[addr];
endmodule

// File: rtl/bus_memory.sv
// bus_memory: word-addressed bus responder with programmable wait states and out-of-window error.
// Optional byte-lane writes enabled by defining BUS_MEMORY_BYTE_SEL_EN.
module bus_memory
  import bus_memory_pkg::*;
#(
  parameter int          ADDR_BITS = 12,
  parameter logic [31:0] BASE      = 32'h0000_1000,
  parameter int          LATENCY   = 0,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] adr_i,
  input  logic [WORD_W-1:0] dat_i,
  output logic [WORD_W-1:0] dat_o,
  input  logic              wen_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              stb_i,
  input  logic              cyc_i,
  output logic              ack_o,
  output logic              err_o,
  output logic              rty_o
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY == 0 ? 0 : LATENCY - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WORD_W-1:0] off;
  logic req, in_range, go;
  assign req = stb_i & cyc_i;
  assign off = adr_i - BASE;
  assign in_range = adr_i >= BASE && (off >> ADDR_BITS) == '0;
  assign rty_o = 1'b0;
  // go marks the edge that enters RESP; the access happens exactly then
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    go = 1'b0;
    case (state)
      IDLE: if (req) begin
        go = !reset && LATENCY == 0;
        state_nxt = LATENCY == 0 ? RESP : WAIT;
        cnt_nxt = LOAD;
      end
      WAIT: begin
        go = !reset && req && cnt == '0;
        state_nxt = !req ? IDLE : cnt == '0 ? RESP : WAIT;
        cnt_nxt = cnt == '0 ? '0 : cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      ack_o <= go & in_range;
      err_o <= go & !in_range;
    end
  bus_memory_array #(.ADDR_BITS(ADDR_BITS), .INIT_FILE(INIT_FILE)) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (go & in_range),
    .we    (go & in_range & wen_i),
    .addr  (off[ADDR_BITS-1:0]),
    .wdata (dat_i),
    .sel   (sel_i),
    .rdata (dat_o)
  );
endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: directed stimulus with a response scoreboard checked by an independent monitor.
module tb_bus_memory;
  localparam int LAT = 3;
  logic clk = 0, reset = 1;
  logic [31:0] adr_i = 0, dat_i = 0, dat_o;
  logic wen_i = 0, stb_i = 0, cyc_i = 0, ack_o, err_o, rty_o;
  logic [3:0] sel_i = 0;
  int ncyc = 0, checks = 0, errors = 0;
  logic prev_resp = 0;
  typedef struct {logic err; logic [31:0] data; int cyc; string name;} exp_t;
  exp_t q[$];
  exp_t e;
`ifdef BUS_MEMORY_BYTE_SEL_EN
  localparam logic [31:0] BYTE_EXP = 32'hFF00FF00;
`else
  localparam logic [31:0] BYTE_EXP = 32'h00000000;
`endif

  bus_memory #(.ADDR_BITS(12), .BASE(32'h1000), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .wen_i(wen_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i),
    .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack_o | err_o) begin
      check("no_back_to_back_resp", 32'(prev_resp), 0);
      if (q.size() == 0) check("unexpected_resp", {30'b0, err_o, ack_o}, 0);
      else begin
        e = q.pop_front();
        check({e.name, "_ack"}, 32'(ack_o), 32'(!e.err));
        check({e.name, "_err"}, 32'(err_o), 32'(e.err));
        check({e.name, "_dat"}, dat_o, e.data);
        check({e.name, "_cycle"}, ncyc, e.cyc);
      end
    end
    prev_resp = ack_o | err_o;
  end

  task automatic wait_resp(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(ack_o | err_o) && n < 50);
    if (n >= 50) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [3:0] s, input logic exp_err, input logic [31:0] exp_dat,
                      input string name);
    @(posedge clk); #1;
    adr_i = a; dat_i = d; wen_i = w; sel_i = s; stb_i = 1; cyc_i = 1;
    q.push_back('{exp_err, exp_dat, ncyc + 1 + LAT, name});
    wait_resp(name);
    @(posedge clk); #1;
    stb_i = 0; cyc_i = 0; wen_i = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_ack", 32'(ack_o), 0);
    check("reset_err", 32'(err_o), 0);
    check("reset_dat", dat_o, 0);
    check("rty_zero", 32'(rty_o), 0);
    xfer(32'h1000, 32'hDEADBEEF, 1, 4'hF, 0, 32'h0, "wr_1000");
    xfer(32'h1000, 32'h0, 0, 4'hF, 0, 32'hDEADBEEF, "rd_1000");
    xfer(32'h1004, 32'h12345678, 1, 4'hF, 0, 32'h0, "wr_1004");
    xfer(32'h1004, 32'h0, 0, 4'hF, 0, 32'h12345678, "rd_1004");
    xfer(32'h100C, 32'hFFFFFFFF, 1, 4'hF, 0, 32'h0, "wr_100c_ones");
    xfer(32'h100C, 32'h00000000, 1, 4'b0101, 0, 32'hFFFFFFFF, "wr_100c_lanes");
    xfer(32'h100C, 32'h0, 0, 4'hF, 0, BYTE_EXP, "rd_100c_lanes");
    xfer(32'h0FFF, 32'h55555555, 1, 4'hF, 1, BYTE_EXP, "err_below");
    xfer(32'h2000, 32'h55555555, 1, 4'hF, 1, BYTE_EXP, "err_above");
    xfer(32'h1000, 32'h0, 0, 4'hF, 0, 32'hDEADBEEF, "rd_1000_after_err");
    xfer(32'h1FFF, 32'h0, 0, 4'hF, 0, 32'h0, "rd_last_word");
    // abort: request seen on two edges only, then dropped while still waiting
    @(posedge clk); #1;
    adr_i = 32'h1008; dat_i = 32'hAAAAAAAA; wen_i = 1; sel_i = 4'hF; stb_i = 1; cyc_i = 1;
    repeat (2) @(posedge clk);
    #1 stb_i = 0; cyc_i = 0; wen_i = 0;
    repeat (8) @(posedge clk);
    xfer(32'h1008, 32'h0, 0, 4'hF, 0, 32'h0, "rd_1008_after_abort");
    xfer(32'h1004, 32'h0, 0, 4'hF, 0, 32'h12345678, "rd_1004_pre_reset");
    // reset lands while the write is in WAIT
    @(posedge clk); #1;
    adr_i = 32'h1004; dat_i = 32'h99999999; wen_i = 1; sel_i = 4'hF; stb_i = 1; cyc_i = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    @(negedge clk);
    check("wait_reset_ack", 32'(ack_o), 0);
    check("wait_reset_err", 32'(err_o), 0);
    check("wait_reset_dat", dat_o, 0);
    #1 reset = 0; stb_i = 0; cyc_i = 0; wen_i = 0;
    xfer(32'h1004, 32'h0, 0, 4'hF, 0, 32'h12345678, "rd_1004_retained");
    // back-to-back: strobe held across three reads
    @(posedge clk); #1;
    adr_i = 32'h1000; wen_i = 0; stb_i = 1; cyc_i = 1;
    for (int i = 0; i < 3; i++)
      q.push_back('{1'b0, 32'hDEADBEEF, ncyc + 1 + LAT + i * (LAT + 2), $sformatf("b2b_%0d", i)});
    for (int i = 0; i < 3; i++) wait_resp("b2b");
    @(posedge clk); #1 stb_i = 0; cyc_i = 0;
    repeat (10) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
